// File: rtl/rt_shared_ram_ctrl.sv
// Shared data RAM controller: round-robin arbitrated requesters, checked
// byte-lane access, per-port counters and a zeroing init/scrub FSM.
//
// Ports:
//   clk_rt_50mhz, rst_n (async, active-low)
//   req_valid/req_ready/req_we/req_be/req_addr/req_wdata : per-port request
//   rsp_valid/rsp_rdata/rsp_err : per-port response, cycle after accept
//   wp_en : arms write-protect window;  clr_req : rescrub pulse
//   ram_ready : high in RUN
//   access_count/contention_count : saturating statistics
module rt_shared_ram_ctrl #(
  parameter int          NUM_PORTS   = 2,
  parameter int          DEPTH_WORDS = 8192,
  parameter logic [31:0] BASE_ADDR   = 32'h0002_0000,
  parameter logic [31:0] WP_BASE     = 32'h0002_0000,
  parameter logic [31:0] WP_SIZE     = 32'h0000_0400
) (
  input  logic                      clk_rt_50mhz,
  input  logic                      rst_n,
  input  logic [NUM_PORTS-1:0]      req_valid,
  output logic [NUM_PORTS-1:0]      req_ready,
  input  logic [NUM_PORTS-1:0]      req_we,
  input  logic [NUM_PORTS*4-1:0]    req_be,
  input  logic [NUM_PORTS*32-1:0]   req_addr,
  input  logic [NUM_PORTS*32-1:0]   req_wdata,
  output logic [NUM_PORTS-1:0]      rsp_valid,
  output logic [NUM_PORTS*32-1:0]   rsp_rdata,
  output logic [NUM_PORTS*2-1:0]    rsp_err,
  input  logic                      wp_en,
  input  logic                      clr_req,
  output logic                      ram_ready,
  output logic [NUM_PORTS*16-1:0]   access_count,
  output logic [15:0]               contention_count
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  // 33-bit bounds so a window touching 2^32 cannot wrap
  localparam logic [32:0] END_ADDR =
    {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [32:0] WP_END =
    {1'b0, WP_BASE} + {1'b0, WP_SIZE};

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   init_ptr_q, init_ptr_d;
  logic [PW-1:0]   last_q, last_d;

  logic [31:0]     mem_q [DEPTH_WORDS];
  logic [31:0]     rd_q;

  logic [NUM_PORTS-1:0] rsp_v_q;
  logic                 rsp_rd_q;
  logic [31:0]          rdat_q [NUM_PORTS];
  logic [1:0]           err_q  [NUM_PORTS];
  logic [15:0]          acc_q  [NUM_PORTS];
  logic [15:0]          cont_q;

  logic [NUM_PORTS-1:0] grant;
  logic [PW-1:0]        gnt_idx;
  logic [PW-1:0]        p;
  logic                 gnt_any;

  logic        a_we;
  logic [3:0]  a_be;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic [31:0] a_mask;
  logic [31:0] a_off;
  logic [32:0] a_addr33;
  logic [AW-1:0] a_idx;
  logic [1:0]  a_err;
  logic        a_ok;
  logic [31:0] a_resp;
  logic        err_range, err_align, err_wp;
  logic        contend;

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    unique case (state_q)
      S_INIT: begin
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == AW'(DEPTH_WORDS - 1))
          state_d = S_RUN;
      end
      S_RUN: begin
        if (clr_req) begin
          init_ptr_d = '0;
          state_d    = S_INIT;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // Scan starts one past the last grant so every port gets a turn
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    p       = '0;
    if (state_q == S_RUN && !clr_req) begin
      for (int k = 1; k <= NUM_PORTS; k++) begin
        p = PW'((int'(last_q) + k) % NUM_PORTS);
        if (!gnt_any && req_valid[p]) begin
          gnt_any = 1'b1;
          gnt_idx = p;
        end
      end
    end
    grant  = gnt_any ? (NUM_PORTS'(1) << gnt_idx) : '0;
    last_d = gnt_any ? gnt_idx : last_q;
  end

  assign req_ready = grant;

  always_comb begin
    a_we     = req_we[gnt_idx];
    a_be     = req_be[4*int'(gnt_idx) +: 4];
    a_addr   = req_addr[32*int'(gnt_idx) +: 32];
    a_wdata  = req_wdata[32*int'(gnt_idx) +: 32];
    a_mask   = {{8{a_be[3]}}, {8{a_be[2]}},
                {8{a_be[1]}}, {8{a_be[0]}}};
    a_addr33 = {1'b0, a_addr};
    a_off    = a_addr - BASE_ADDR;
    a_idx    = AW'(a_off >> 2);
    err_range = (a_addr33 < {1'b0, BASE_ADDR}) ||
                (a_addr33 >= END_ADDR);
    err_align = |a_addr[1:0];
    err_wp    = a_we && wp_en &&
                (a_addr33 >= {1'b0, WP_BASE}) &&
                (a_addr33 < WP_END);
    priority case (1'b1)
      err_range: a_err = 2'b01;
      err_align: a_err = 2'b10;
      err_wp:    a_err = 2'b11;
      default:   a_err = 2'b00;
    endcase
    a_ok   = gnt_any && (a_err == 2'b00);
    a_resp = !a_ok ? 32'hDEAD_BEEF :
             a_we  ? (a_wdata & a_mask) : 32'h0;
  end

  assign contend = (state_q == S_RUN) &&
                   ($countones(req_valid) >= 2);

  always_ff @(posedge clk_rt_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_INIT;
      init_ptr_q <= '0;
      last_q     <= PW'(NUM_PORTS - 1);
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      last_q     <= last_d;
    end
  end

  // RAM array: no reset, contents are zeroed by the INIT sweep
  always_ff @(posedge clk_rt_50mhz) begin
    if (state_q == S_INIT) begin
      mem_q[init_ptr_q] <= '0;
    end else if (a_ok && a_we) begin
      for (int b = 0; b < 4; b++)
        if (a_be[b])
          mem_q[a_idx][8*b +: 8] <= a_wdata[8*b +: 8];
    end
    rd_q <= mem_q[a_idx];
  end

  // Read data arrives in rd_q; it is copied into the hold register
  // at the end of the response cycle so it persists afterwards.
  always_ff @(posedge clk_rt_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      rsp_v_q  <= '0;
      rsp_rd_q <= 1'b0;
      cont_q   <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        rdat_q[i] <= '0;
        err_q[i]  <= '0;
        acc_q[i]  <= '0;
      end
    end else begin
      rsp_v_q  <= grant;
      rsp_rd_q <= a_ok && !a_we;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (grant[i]) begin
          rdat_q[i] <= a_resp;
          err_q[i]  <= a_err;
          if (acc_q[i] != 16'hFFFF)
            acc_q[i] <= acc_q[i] + 16'd1;
        end else if (rsp_v_q[i] && rsp_rd_q) begin
          rdat_q[i] <= rd_q;
        end
      end
      if (contend && cont_q != 16'hFFFF)
        cont_q <= cont_q + 16'd1;
    end
  end

  always_comb begin
    rsp_rdata    = '0;
    rsp_err      = '0;
    access_count = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      rsp_rdata[32*i +: 32] =
        (rsp_v_q[i] && rsp_rd_q) ? rd_q : rdat_q[i];
      rsp_err[2*i +: 2]       = err_q[i];
      access_count[16*i +: 16] = acc_q[i];
    end
  end

  assign rsp_valid        = rsp_v_q;
  assign ram_ready        = (state_q == S_RUN);
  assign contention_count = cont_q;

endmodule

// File: tb/tb_rt_shared_ram_ctrl.sv
// Bench for rt_shared_ram_ctrl: directed scenarios plus random traffic
// scored against a word-array reference model.
module tb_rt_shared_ram_ctrl;

  localparam int          N    = 2;
  localparam int          D    = 16;
  localparam logic [31:0] BASE = 32'h0002_0000;
  localparam logic [31:0] WPB  = 32'h0002_0000;
  localparam logic [31:0] WPS  = 32'h0000_0010;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_we = '0;
  logic [N*4-1:0]  req_be = '0;
  logic [N*32-1:0] req_addr = '0;
  logic [N*32-1:0] req_wdata = '0;
  logic [N-1:0]    rsp_valid;
  logic [N*32-1:0] rsp_rdata;
  logic [N*2-1:0]  rsp_err;
  logic            wp_en = 1'b0;
  logic            clr_req = 1'b0;
  logic            ram_ready;
  logic [N*16-1:0] access_count;
  logic [15:0]     contention_count;

  always #10 clk = ~clk;

  rt_shared_ram_ctrl #(
    .NUM_PORTS(N), .DEPTH_WORDS(D), .BASE_ADDR(BASE),
    .WP_BASE(WPB), .WP_SIZE(WPS)
  ) dut (
    .clk_rt_50mhz(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_be(req_be),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .wp_en(wp_en), .clr_req(clr_req),
    .ram_ready(ram_ready), .access_count(access_count),
    .contention_count(contention_count)
  );

  int npass = 0;
  int nchk  = 0;

  logic [31:0] mdl_mem [D];
  logic [31:0] exp_rd  [N];
  logic [1:0]  exp_er  [N];
  int          acc     [N];
  int          cont;
  int          lg;
  int          init_left;

  task automatic chk(string tag, logic [31:0] act,
                     logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h", tag, act, exp);
  endtask

  function automatic logic [1:0] ref_err(logic [31:0] a,
                                         logic we, logic wp);
    longint la = longint'(a);
    if (la < longint'(BASE) || la >= longint'(BASE) + D * 4)
      return 2'b01;
    if (a % 4 != 0) return 2'b10;
    if (we && wp && la >= longint'(WPB) &&
        la < longint'(WPB) + longint'(WPS))
      return 2'b11;
    return 2'b00;
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < D; i++) mdl_mem[i] = '0;
    for (int i = 0; i < N; i++) begin
      exp_rd[i] = '0; exp_er[i] = '0; acc[i] = 0;
    end
    cont = 0; lg = N - 1; init_left = D;
  endtask

  // One clock: check pre-edge grant, advance model, check responses.
  task automatic step(output int g);
    logic [N-1:0] er;
    logic [31:0]  a, wd, m, d;
    logic [1:0]   e;
    int           run, idx;
    #1;
    run = (init_left == 0) ? 1 : 0;
    chk("ram_ready", 32'(ram_ready), 32'(run));
    g  = -1;
    er = '0;
    if (run == 1 && !clr_req)
      for (int k = 1; k <= N; k++) begin
        int q = (lg + k) % N;
        if (g < 0 && req_valid[q]) g = q;
      end
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    if (run == 1 && $countones(req_valid) >= 2 && cont < 65535)
      cont++;
    if (g >= 0) begin
      a  = req_addr[32*g +: 32];
      wd = req_wdata[32*g +: 32];
      e  = ref_err(a, req_we[g], wp_en);
      m  = '0;
      for (int b = 0; b < 4; b++)
        if (req_be[4*g + b]) m[8*b +: 8] = 8'hFF;
      if (e != 2'b00) d = 32'hDEAD_BEEF;
      else begin
        idx = int'((a - BASE) / 4);
        if (req_we[g]) begin
          d = wd & m;
          mdl_mem[idx] = (mdl_mem[idx] & ~m) | d;
        end else d = mdl_mem[idx];
      end
      exp_rd[g] = d;
      exp_er[g] = e;
      lg = g;
      if (acc[g] < 65535) acc[g]++;
    end
    if (run == 1 && clr_req) begin
      init_left = D;
      for (int i = 0; i < D; i++) mdl_mem[i] = '0;
    end else if (run == 0) init_left--;
    @(posedge clk);
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'(er));
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rdata%0d", i), rsp_rdata[32*i +: 32], exp_rd[i]);
      chk($sformatf("err%0d", i), 32'(rsp_err[2*i +: 2]),
          32'(exp_er[i]));
      chk($sformatf("acc%0d", i), 32'(access_count[16*i +: 16]),
          32'(acc[i]));
    end
    chk("contention", 32'(contention_count), 32'(cont));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_ram_ready", 32'(ram_ready), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    mdl_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_req(int q, logic we, logic [3:0] be,
                         logic [31:0] a, logic [31:0] wd);
    req_we[q]            = we;
    req_be[4*q +: 4]     = be;
    req_addr[32*q +: 32] = a;
    req_wdata[32*q +: 32] = wd;
    req_valid[q]         = 1'b1;
  endtask

  task automatic req_one(int q, logic we, logic [3:0] be,
                         logic [31:0] a, logic [31:0] wd);
    int g = -1;
    set_req(q, we, be, a, wd);
    for (int t = 0; t < 8 && g != q; t++) step(g);
    req_valid[q] = 1'b0;
    chk("grant_bound", 32'(g), 32'(q));
  endtask

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(0, 9))
      0: return BASE - 4 * $urandom_range(1, 8);
      1: return BASE + D * 4 + 4 * $urandom_range(0, 8);
      2: return BASE + 4 * $urandom_range(0, D - 1)
                + $urandom_range(1, 3);
      default: return BASE + 4 * $urandom_range(0, D - 1);
    endcase
  endfunction

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    #2;
    do_reset();

    set_req(0, 1'b0, 4'hF, BASE, 32'h0);
    set_req(1, 1'b0, 4'hF, BASE + 4, 32'h0);
    repeat (D) step(g);
    chk("ram_ready_up", 32'(ram_ready), 32'd1);
    req_valid = '0;
    for (int w = 0; w < D; w++)
      req_one(0, 1'b0, 4'hF, BASE + 4 * w, 32'h0);

    req_one(0, 1'b1, 4'hF, BASE + 8, 32'h1122_3344);
    req_one(0, 1'b1, 4'b0101, BASE + 8, 32'hAABB_CCDD);
    chk("t2_wresp", rsp_rdata[31:0], 32'h00BB_00DD);
    req_one(0, 1'b0, 4'hF, BASE + 8, 32'h0);
    chk("t2_rb", rsp_rdata[31:0], 32'h11BB_33DD);

    set_req(0, 1'b0, 4'hF, BASE + 8, 32'h0);
    set_req(1, 1'b0, 4'hF, BASE + 12, 32'h0);
    repeat (4) step(g);
    req_valid = '0;

    req_one(1, 1'b0, 4'hF, 32'h0001_FFFC, 32'h0);
    chk("t4_lo", 32'(rsp_err[3:2]), 32'd1);
    req_one(1, 1'b0, 4'hF, BASE + D * 4, 32'h0);
    chk("t4_hi", 32'(rsp_err[3:2]), 32'd1);
    req_one(1, 1'b0, 4'hF, BASE + 2, 32'h0);
    chk("t4_mis", 32'(rsp_err[3:2]), 32'd2);
    chk("t4_data", rsp_rdata[63:32], 32'hDEAD_BEEF);

    wp_en = 1'b1;
    req_one(0, 1'b1, 4'hF, BASE, 32'h5555_5555);
    chk("t5_wp", 32'(rsp_err[1:0]), 32'd3);
    req_one(0, 1'b0, 4'hF, BASE, 32'h0);
    chk("t5_rd", 32'(rsp_err[1:0]), 32'd0);
    wp_en = 1'b0;
    req_one(0, 1'b1, 4'hF, BASE, 32'h5555_5555);
    chk("t5_wr", 32'(rsp_err[1:0]), 32'd0);

    set_req(0, 1'b0, 4'hF, BASE, 32'h0);
    repeat (2) step(g);
    clr_req = 1'b1;
    step(g);
    clr_req = 1'b0;
    repeat (D) step(g);
    req_valid = '0;
    for (int w = 0; w < D; w++)
      req_one(0, 1'b0, 4'hF, BASE + 4 * w, 32'h0);

    set_req(0, 1'b1, 4'hF, BASE + 20, 32'hCAFE_F00D);
    step(g);
    do_reset();
    req_valid = '0;
    repeat (D) step(g);

    for (int c = 0; c < 600; c++) begin
      for (int q = 0; q < N; q++)
        if (!req_valid[q] && $urandom_range(0, 99) < 55)
          set_req(q, 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), rnd_addr(),
                  $urandom);
      wp_en   = ($urandom_range(0, 3) == 0);
      clr_req = ($urandom_range(0, 149) == 0);
      step(g);
      if (g >= 0) req_valid[g] = 1'b0;
    end
    clr_req = 1'b0;

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/rt_shared_ram_ctrl.md
Name: rt_shared_ram_ctrl

Overview:
Parametrised multi-requester data RAM controller in the RT-Core 50 MHz domain. NUM_PORTS requesters (RT pipeline, DMA, debug) share one single-port block RAM partition through a round-robin arbiter with valid/ready handshakes. Each access gets byte-lane writes, bounds/alignment/write-protect checking with coded errors, and per-port access counters. A hardware init/scrub FSM zeroes the RAM after reset or on request.

Parameters:
NUM_PORTS, 2, number of requesters (1..8)
DEPTH_WORDS, 8192, RAM depth in 32-bit words (power of 2)
BASE_ADDR, 32'h00020000, byte address of word 0
WP_BASE, 32'h00020000, byte base of the write-protect window
WP_SIZE, 32'h00000400, write-protect window size in bytes (0 = none)

Ports:
clk_rt_50mhz  in  1  clock
rst_n  in  1  reset
req_valid  in  NUM_PORTS  request valid per port
req_ready  out  NUM_PORTS  grant; accept when valid&&ready
req_we  in  NUM_PORTS  1 = write
req_be  in  NUM_PORTS*4  byte enables, port i at [4i+3:4i]
req_addr  in  NUM_PORTS*32  byte address, port i at [32i+31:32i]
req_wdata  in  NUM_PORTS*32  write data
rsp_valid  out  NUM_PORTS  response valid (1-cycle pulse)
rsp_rdata  out  NUM_PORTS*32  response data
rsp_err  out  NUM_PORTS*2  00 ok, 01 range, 10 misaligned, 11 write-protect
wp_en  in  1  enables the write-protect window
clr_req  in  1  pulse: rescrub RAM
ram_ready  out  1  1 in RUN state
access_count  out  NUM_PORTS*16  accepted requests per port, saturating
contention_count  out  16  cycles with >=2 valid in RUN, saturating

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk_rt_50mhz. All outputs 0. FSM = INIT. Init pointer = 0. Round-robin pointer = NUM_PORTS-1, so port 0 has first priority.
- FSM INIT:
  - Writes 0 to word[ptr] each cycle, ptr increments.
  - After writing word DEPTH_WORDS-1, the next state is RUN.
  - ram_ready is 0 in INIT. ram_ready rises exactly DEPTH_WORDS cycles after the first clock edge with rst_n high.
  - req_ready = 0 throughout INIT.
- FSM RUN:
  - ram_ready = 1.
  - If clr_req = 1 this cycle: no grant this cycle (req_ready = 0), ptr cleared, next state INIT.
  - Responses for requests accepted in the previous cycle are still delivered.
- Arbitration (RUN, clr_req = 0):
  - req_ready is combinational: one-hot to the first valid port scanning from last_grant+1 with wrap-around.
  - On accept, last_grant takes the granted index.
  - req_ready may depend on req_valid. A requester must hold request fields stable until accepted.
  - At most one accept per cycle. A lone requester is granted every cycle (back-to-back).
- Checks on the accepted request, in priority order:
  - Range: addr < BASE_ADDR, or addr >= BASE_ADDR + DEPTH_WORDS*4 (computed 33-bit, no overflow) -> 01.
  - Alignment: addr[1:0] != 0 -> 10.
  - Protect: we && wp_en && addr in [WP_BASE, WP_BASE+WP_SIZE) -> 11.
  - Reads of the protect window are always allowed.
- Execution: word index = (addr - BASE_ADDR) >> 2, $clog2(DEPTH_WORDS) bits.
  - Valid write: only lanes with be = 1 are updated. be = 4'b0000 is a no-op with ok response.
  - Error: RAM untouched.
- Response, cycle after accept: rsp_valid[i] = 1 for 1 cycle.
  - Read ok: rdata = RAM word.
  - Write ok: rdata = wdata with disabled lanes zeroed.
  - Error: rdata = 32'hDEADBEEF.
  - rsp_err holds its code. When rsp_valid = 0, rsp_rdata/rsp_err hold their last values.
- Read-after-write: a read accepted the cycle after a write to the same word returns the new data (no forwarding needed with a single port).
- Counters:
  - access_count[i] += 1 on each accept, including errored accepts; saturates at 16'hFFFF.
  - contention_count += 1 per RUN cycle with popcount(req_valid) >= 2; saturates.
  - Counters are not cleared by clr_req.
- Reset mid-operation: pending responses are dropped, FSM returns to INIT, and the RAM is re-zeroed.

Test Plan:
1. DEPTH_WORDS=16, release reset, all req_valid high -> req_ready=0 for 16 cycles, ram_ready=1 on cycle 16, then reads of 0x00020000..0x0002003C all return 0 with err 00.
2. Port0 write 0x00020008 be=4'b0101 wdata=0xAABBCCDD over 0x11223344 -> rsp_rdata 0x00BB00DD err 00; read back returns 0x11BB33DD one cycle after accept.
3. Ports 0 and 1 both valid for 4 cycles -> grants 0,1,0,1; contention_count=4; access_count=2 each.
4. Reads of 0x0001FFFC, 0x00020040, 0x00020002 -> err 01, 01, 10, rdata 0xDEADBEEF, RAM unchanged.
5. wp_en=1, write 0x00020000 -> err 11, word unchanged; read same address -> err 00. wp_en=0, same write -> err 00.
6. clr_req pulse during continuous port0 traffic -> no grant that cycle, prior response still delivered, ram_ready low 16 cycles, all words read 0 afterwards. rst_n pulsed mid-transfer -> rsp_valid=0 immediately and INIT restarts.
